// File: rtl/mtl_stream_receiver.sv
// ---------------------------------------------------------------------------
// mtl_stream_receiver
//
// Sink for the MTL LCD stream (HD/VD sync + 24-bit RGB). It rebuilds pixel
// coordinates from the sync pulses and checks that line and frame periods
// match the nominal timing. Active pixels are re-emitted with their (x,y)
// position. A per-frame R+G+B checksum is also produced, so displayed frames
// can be verified without a panel attached.
//
// Ports
//   iCLK, iRST_n        pixel clock (rising edge), async active-low reset
//   iHD                 horizontal sync, low for one clock at line start
//   iVD                 vertical sync, low for the whole of line 0
//   iLCD_R/G/B [7:0]    colour data
//   oPixValid           active pixel present on oX/oY/oR/oG/oB
//   oX [9:0], oY [8:0]  active column / line
//   oR/oG/oB [7:0]      registered colour of the active pixel
//   oLocked             receiver is synchronised to the stream
//   oLineErr            1-clock pulse, HD period wrong or HD missing
//   oFrameErr           1-clock pulse, VD period wrong (locked only)
//   oFrameDone          1-clock pulse, clean frame finished, oFrameSum valid
//   oFrameSum [31:0]    R+G+B sum over the active area of the last clean frame
//
// Timing model: hc is the registered column count. The clock on which iHD is
// sampled low has hc == H_LINE-1, and column 0 is the clock after it. The
// coordinates and colour of an active pixel appear one clock after sampling.
// ---------------------------------------------------------------------------
module mtl_stream_receiver #(
  parameter int H_LINE  = 1056,
  parameter int V_LINE  = 525,
  parameter int H_BLANK = 46,
  parameter int V_BLANK = 23,
  parameter int H_ACT   = 800,
  parameter int V_ACT   = 480
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iHD,
  input  logic        iVD,
  input  logic [7:0]  iLCD_R,
  input  logic [7:0]  iLCD_G,
  input  logic [7:0]  iLCD_B,
  output logic        oPixValid,
  output logic [9:0]  oX,
  output logic [8:0]  oY,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic        oLocked,
  output logic        oLineErr,
  output logic        oFrameErr,
  output logic        oFrameDone,
  output logic [31:0] oFrameSum
);

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_LINE_SYNC = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  localparam logic [10:0] HC_LAST = 11'(H_LINE - 1);
  localparam logic [10:0] HC_MAX  = 11'h7FF;
  localparam logic [10:0] X_FIRST = 11'(H_BLANK);
  localparam logic [10:0] X_LAST  = 11'(H_BLANK + H_ACT - 1);
  localparam logic [9:0]  VC_LAST = 10'(V_LINE - 1);
  localparam logic [9:0]  VC_MAX  = 10'h3FF;
  localparam logic [9:0]  Y_FIRST = 10'(V_BLANK);
  localparam logic [9:0]  Y_LAST  = 10'(V_BLANK + V_ACT - 1);

  state_t      state, state_next;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        prev_vd;
  logic [31:0] acc;

  logic        hd_low;
  logic        vd_fall;
  logic        syncing;
  logic        hd_missing;
  logic        line_start;
  logic        line_err;
  logic        frame_err;
  logic        active;
  logic        last_pix;
  logic [9:0]  pix_sum;
  logic [31:0] acc_sum;

  // Event decode. A missing HD is treated as a virtual HD, so hc and vc stay
  // in phase with the stream while the error is reported.
  assign hd_low     = !iHD;
  assign vd_fall    = !iVD && prev_vd;
  assign syncing    = (state != ST_SEARCH);
  assign hd_missing = syncing && iHD && (hc == HC_LAST);
  assign line_start = hd_low || hd_missing;
  assign line_err   = syncing && ((hd_low && (hc != HC_LAST)) || hd_missing);
  // vc still holds the index of the last line when VD falls, so a full
  // frame shows vc == V_LINE-1 here.
  assign frame_err  = (state == ST_LOCKED) && vd_fall && (vc != VC_LAST);

  assign active   = (state == ST_LOCKED) &&
                    (hc >= X_FIRST) && (hc <= X_LAST) &&
                    (vc >= Y_FIRST) && (vc <= Y_LAST);
  assign last_pix = active && (hc == X_LAST) && (vc == Y_LAST);
  assign pix_sum  = {2'b00, iLCD_R} + {2'b00, iLCD_G} + {2'b00, iLCD_B};
  assign acc_sum  = acc + {22'd0, pix_sum};

  assign oLocked  = (state == ST_LOCKED);

  // Any error leaves LOCKED, and LOCKED is only re-entered on a VD fall. So
  // a frame whose last pixel is seen while locked is clean from its start.
  // NOTE: every output of a combinational block gets a default first, so no
  //       path through the case statement can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_SEARCH:    if (hd_low) state_next = ST_LINE_SYNC;
      ST_LINE_SYNC: if (!line_err && vd_fall) state_next = ST_LOCKED;
      ST_LOCKED:    if (line_err || frame_err) state_next = ST_LINE_SYNC;
      default:      state_next = ST_SEARCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  //       then samples pre-edge values, whatever the statement order.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= ST_SEARCH;
      hc      <= '0;
      vc      <= '0;
      prev_vd <= 1'b1;
      acc     <= '0;
    end else begin
      state   <= state_next;
      prev_vd <= iVD;

      if (line_start)        hc <= '0;
      else if (hc != HC_MAX) hc <= hc + 11'd1;

      if (line_start) begin
        if (vd_fall)           vc <= '0;
        else if (vc != VC_MAX) vc <= vc + 10'd1;
      end

      if (vd_fall)     acc <= '0;
      else if (active) acc <= acc_sum;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oPixValid  <= 1'b0;
      oX         <= '0;
      oY         <= '0;
      oR         <= '0;
      oG         <= '0;
      oB         <= '0;
      oLineErr   <= 1'b0;
      oFrameErr  <= 1'b0;
      oFrameDone <= 1'b0;
      oFrameSum  <= '0;
    end else begin
      oPixValid  <= active;
      oX         <= active ? 10'(hc - X_FIRST) : 10'd0;
      oY         <= active ? 9'(vc - Y_FIRST)  : 9'd0;
      oR         <= active ? iLCD_R : 8'd0;
      oG         <= active ? iLCD_G : 8'd0;
      oB         <= active ? iLCD_B : 8'd0;
      oLineErr   <= line_err;
      oFrameErr  <= frame_err;
      oFrameDone <= last_pix;
      if (last_pix) oFrameSum <= acc_sum;
    end
  end

endmodule

// File: tb/tb_mtl_stream_receiver.sv
// ---------------------------------------------------------------------------
// tb_mtl_stream_receiver
//
// Directed bench for mtl_stream_receiver. The DUT runs with reduced timing
// so that many frames fit in a short run: 40 clocks/line, 20 lines/frame,
// and a 24x12 active area starting at column 6, line 3. Each generated line
// starts with its HD clock, and line 0 holds VD low. A negedge monitor counts
// the output events and checks each pixel. The main sequence compares those
// counts with hand-computed values.
// ---------------------------------------------------------------------------
module tb_mtl_stream_receiver;

  localparam int HL = 40;
  localparam int VL = 20;
  localparam int HB = 6;
  localparam int VB = 3;
  localparam int HA = 24;
  localparam int VA = 12;

  // 24*12 pixels * 765
  localparam int SUM_WHITE = 220320;
  // sum x (0..23) * 12 lines + sum y (0..11) * 24 columns = 3312 + 1584
  localparam int SUM_PAT   = 4896;
  localparam int NPIX      = 288;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic        iHD;
  logic        iVD;
  logic [7:0]  iLCD_R, iLCD_G, iLCD_B;
  logic        oPixValid;
  logic [9:0]  oX;
  logic [8:0]  oY;
  logic [7:0]  oR, oG, oB;
  logic        oLocked, oLineErr, oFrameErr, oFrameDone;
  logic [31:0] oFrameSum;

  mtl_stream_receiver #(
    .H_LINE (HL), .V_LINE (VL), .H_BLANK(HB),
    .V_BLANK(VB), .H_ACT  (HA), .V_ACT  (VA)
  ) dut (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .iHD       (iHD),
    .iVD       (iVD),
    .iLCD_R    (iLCD_R),
    .iLCD_G    (iLCD_G),
    .iLCD_B    (iLCD_B),
    .oPixValid (oPixValid),
    .oX        (oX),
    .oY        (oY),
    .oR        (oR),
    .oG        (oG),
    .oB        (oB),
    .oLocked   (oLocked),
    .oLineErr  (oLineErr),
    .oFrameErr (oFrameErr),
    .oFrameDone(oFrameDone),
    .oFrameSum (oFrameSum)
  );

  always #5 iCLK = ~iCLK;

  int checks   = 0;
  int failures = 0;
  bit pat_mode = 1'b0;

  // monitor-owned counters
  int le_cnt = 0, fe_cnt = 0, done_cnt = 0, valid_cnt = 0;
  int pat_bad = 0, idle_bad = 0, done_pos_bad = 0;
  int first_x = -1, first_y = -1;
  bit want_first = 1'b0;

  // snapshots taken by the main sequence
  int b_le, b_fe, b_done, b_valid, b_pat;

  always @(negedge iCLK) begin
    if (oLineErr)   le_cnt++;
    if (oFrameErr)  fe_cnt++;
    if (oFrameDone) done_cnt++;
    if (oPixValid) begin
      valid_cnt++;
      if (pat_mode && (oR !== oX[7:0] || oG !== 8'(oY) || oB !== 8'd0)) pat_bad++;
      if (want_first) begin
        first_x    = int'(oX);
        first_y    = int'(oY);
        want_first = 1'b0;
      end
    end else if (oX !== 10'd0 || oY !== 9'd0 || oR !== 8'd0 || oG !== 8'd0 || oB !== 8'd0) begin
      idle_bad++;
    end
    if (oFrameDone && !(oPixValid && oX == 10'(HA - 1) && oY == 9'(VA - 1))) done_pos_bad++;
    if (!iVD) want_first = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outs(input string pfx);
    check({pfx, "_valid"}, 32'(oPixValid), 32'd0);
    check({pfx, "_x"},     32'(oX), 32'd0);
    check({pfx, "_y"},     32'(oY), 32'd0);
    check({pfx, "_rgb"},   32'({oR, oG, oB}), 32'd0);
    check({pfx, "_flags"}, 32'({oLocked, oLineErr, oFrameErr, oFrameDone}), 32'd0);
    check({pfx, "_sum"},   oFrameSum, 32'd0);
  endtask

  task automatic snap();
    b_le    = le_cnt;
    b_fe    = fe_cnt;
    b_done  = done_cnt;
    b_valid = valid_cnt;
    b_pat   = pat_bad;
  endtask

  // Drives len clocks of line 'line'. Clock c is sampled on the c-th edge,
  // and c=0 is the HD clock. The DUT sees column c-1 of line 'line' on
  // clock c.
  task automatic send_line(input int line, input int len, input bit hd_on);
    for (int c = 0; c < len; c++) begin
      @(posedge iCLK);
      #1;
      iHD = (c == 0 && hd_on) ? 1'b0 : 1'b1;
      iVD = (line == 0) ? 1'b0 : 1'b1;
      if (pat_mode) begin
        iLCD_R = 8'(c - 1 - HB);
        iLCD_G = 8'(line - VB);
        iLCD_B = 8'd0;
      end else begin
        iLCD_R = 8'd255;
        iLCD_G = 8'd255;
        iLCD_B = 8'd255;
      end
    end
  endtask

  task automatic send_lines(input int first, input int last, input int short_line,
                            input int short_len, input int nohd_line);
    for (int l = first; l <= last; l++)
      send_line(l, (l == short_line) ? short_len : HL, l != nohd_line);
  endtask

  task automatic send_frame();
    send_lines(0, VL - 1, -1, 0, -1);
  endtask

  // Checks for a frame that locks cleanly and completes with checksum 'sum'.
  task automatic check_clean(input string pfx, input int sum);
    check({pfx, "_locked"},  32'(oLocked), 32'd1);
    check({pfx, "_done"},    32'(done_cnt - b_done), 32'd1);
    check({pfx, "_sum"},     oFrameSum, 32'(sum));
    check({pfx, "_lineerr"}, 32'(le_cnt - b_le), 32'd0);
    check({pfx, "_frameerr"},32'(fe_cnt - b_fe), 32'd0);
  endtask

  initial begin
    iRST_n = 1'b0;
    iHD    = 1'b1;
    iVD    = 1'b1;
    iLCD_R = 8'd0;
    iLCD_G = 8'd0;
    iLCD_B = 8'd0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check_zero_outs("reset");
    @(posedge iCLK);
    #1 iRST_n = 1'b1;

    // Lead-in: two tail lines. The first HD moves the DUT to LINE_SYNC only.
    send_lines(VL - 2, VL - 1, -1, 0, -1);
    check("leadin_unlocked", 32'(oLocked), 32'd0);

    // 1. nominal white frames: lock at the first VD fall, sum each frame
    snap();
    send_frame();
    check_clean("white1", SUM_WHITE);
    check("white1_pixels", 32'(valid_cnt - b_valid), 32'(NPIX));
    snap();
    send_frame();
    check_clean("white2", SUM_WHITE);

    // 2. coordinate pattern R=x, G=y, B=0
    pat_mode = 1'b1;
    snap();
    send_frame();
    check("pat_pixels",  32'(valid_cnt - b_valid), 32'(NPIX));
    check("pat_bad",     32'(pat_bad - b_pat), 32'd0);
    check("pat_first_x", 32'(first_x), 32'd0);
    check("pat_first_y", 32'(first_y), 32'd0);
    check_clean("pat", SUM_PAT);
    pat_mode = 1'b0;

    // 3. line 8 shortened by 6 clocks: one line error, no frame done, sum kept
    snap();
    send_lines(0, VL - 1, 8, HL - 6, -1);
    check("short_lineerr",  32'(le_cnt - b_le), 32'd1);
    check("short_unlocked", 32'(oLocked), 32'd0);
    check("short_nodone",   32'(done_cnt - b_done), 32'd0);
    check("short_sumkept",  oFrameSum, 32'(SUM_PAT));
    snap();
    send_frame();
    check_clean("relock3", SUM_WHITE);

    // 4. frame of VL-1 lines: the error shows at the next VD fall
    snap();
    send_lines(0, VL - 2, -1, 0, -1);
    check("frame19_done", 32'(done_cnt - b_done), 32'd1);
    snap();
    send_lines(0, 0, -1, 0, -1);
    check("frame19_frameerr", 32'(fe_cnt - b_fe), 32'd1);
    check("frame19_lineerr",  32'(le_cnt - b_le), 32'd0);
    check("frame19_unlocked", 32'(oLocked), 32'd0);
    send_lines(1, VL - 1, -1, 0, -1);
    check("frame19_nodone",   32'(done_cnt - b_done), 32'd0);
    check("frame19_stillunl", 32'(oLocked), 32'd0);
    snap();
    send_frame();
    check_clean("relock4", SUM_WHITE);

    // 5. HD missing on line 8: exactly one line error, counters stay in phase
    snap();
    send_lines(0, VL - 1, -1, 0, 8);
    check("nohd_lineerr",  32'(le_cnt - b_le), 32'd1);
    check("nohd_unlocked", 32'(oLocked), 32'd0);
    check("nohd_nodone",   32'(done_cnt - b_done), 32'd0);
    snap();
    send_frame();
    check_clean("relock5", SUM_WHITE);
    check("relock5_pixels", 32'(valid_cnt - b_valid), 32'(NPIX));

    // 6. reset pulse inside the active area
    snap();
    send_lines(0, 7, -1, 0, -1);
    send_line(8, 20, 1'b1);
    @(negedge iCLK);
    check("prerst_valid", 32'(oPixValid), 32'd1);
    #1 iRST_n = 1'b0;
    #1 check_zero_outs("midrst");
    repeat (2) @(posedge iCLK);
    #1 iRST_n = 1'b1;
    send_lines(9, VL - 1, -1, 0, -1);
    check("postrst_nodone",   32'(done_cnt - b_done), 32'd0);
    check("postrst_unlocked", 32'(oLocked), 32'd0);
    check("postrst_sum0",     oFrameSum, 32'd0);
    snap();
    send_frame();
    check_clean("relock6", SUM_WHITE);

    check("idle_outputs_zero", 32'(idle_bad), 32'd0);
    check("done_with_last_px", 32'(done_pos_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
